// File: rtl/rotate_pkg.sv
// Shared definitions for the tile rotation scheduler: FSM encoding, default
// tile edge and quarter-turn rotation codes.
package rotate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD,
    ST_CORE,
    ST_CORE_WAIT,
    ST_WR,
    ST_NEXT,
    ST_FIN
  } state_t;

  localparam int TILE_DEF = 8;

  localparam logic [1:0] ROT_0   = 2'd0;
  localparam logic [1:0] ROT_90  = 2'd1;
  localparam logic [1:0] ROT_180 = 2'd2;
  localparam logic [1:0] ROT_270 = 2'd3;

  // A counter-clockwise turn is the same as (4 - deg) clockwise quarter turns.
  function automatic logic [1:0] norm_rot(input logic [1:0] deg, input logic dir);
    return dir ? (2'd0 - deg) : deg;
  endfunction

endpackage

// File: rtl/rotate_tile_sched_if.sv
// Job, DMA and core handshake bundle of the tile rotation scheduler.
// The scheduler uses the master view; the surrounding system uses slave.
interface rotate_tile_sched_if;
  logic        I_START;
  logic [15:0] I_HEIGHT;
  logic [15:0] I_WIDTH;
  logic [1:0]  I_DEGREES;
  logic        I_DIRECTION;
  logic        O_DMA_RD_REQ;
  logic [31:0] O_DMA_RD_OFS;
  logic        I_DMA_RD_DONE;
  logic        O_CORE_START;
  logic        I_CORE_DONE;
  logic        O_DMA_WR_REQ;
  logic [31:0] O_DMA_WR_OFS;
  logic        I_DMA_WR_DONE;
  logic        O_BUSY;
  logic        O_DONE;
  logic        O_ERR;

  modport master (
    input  I_START, I_HEIGHT, I_WIDTH, I_DEGREES, I_DIRECTION,
    input  I_DMA_RD_DONE, I_CORE_DONE, I_DMA_WR_DONE,
    output O_DMA_RD_REQ, O_DMA_RD_OFS, O_CORE_START,
    output O_DMA_WR_REQ, O_DMA_WR_OFS, O_BUSY, O_DONE, O_ERR
  );

  modport slave (
    output I_START, I_HEIGHT, I_WIDTH, I_DEGREES, I_DIRECTION,
    output I_DMA_RD_DONE, I_CORE_DONE, I_DMA_WR_DONE,
    input  O_DMA_RD_REQ, O_DMA_RD_OFS, O_CORE_START,
    input  O_DMA_WR_REQ, O_DMA_WR_OFS, O_BUSY, O_DONE, O_ERR
  );
endinterface

// File: rtl/rotate_tile_addr.sv
// Combinational source/destination tile pixel offsets for one tile of a
// rotated image; all arithmetic is 32-bit unsigned and wraps.
module rotate_tile_addr
  import rotate_pkg::*;
#(
  parameter int TILE = TILE_DEF
) (
  input  logic [15:0] tx,
  input  logic [15:0] ty,
  input  logic [15:0] tw,
  input  logic [15:0] th,
  input  logic [15:0] w,
  input  logic [15:0] h,
  input  logic [1:0]  rot,
  output logic [31:0] rd_ofs,
  output logic [31:0] wr_ofs
);

  logic [31:0] dx, dy, dw;

  // Destination tile coordinates and row pitch; 90/270 swap the image edges.
  always_comb begin
    dx = 32'(tx);
    dy = 32'(ty);
    dw = 32'(w);
    case (rot)
      ROT_90: begin
        dx = 32'(th) - 32'(ty) - 32'd1;
        dy = 32'(tx);
        dw = 32'(h);
      end
      ROT_180: begin
        dx = 32'(tw) - 32'(tx) - 32'd1;
        dy = 32'(th) - 32'(ty) - 32'd1;
      end
      ROT_270: begin
        dx = 32'(ty);
        dy = 32'(tw) - 32'(tx) - 32'd1;
        dw = 32'(h);
      end
      default: ;
    endcase
  end

  assign rd_ofs = 32'(ty) * 32'(TILE) * 32'(w) + 32'(tx) * 32'(TILE);
  assign wr_ofs = dy * 32'(TILE) * dw + dx * 32'(TILE);

endmodule

// File: rtl/rotate_tile_sched.sv
// Tile rotation scheduler: walks the source image tile by tile, issuing a
// DMA read, a core run and a DMA write to the rotated destination per tile.
module rotate_tile_sched
  import rotate_pkg::*;
#(
  parameter int TILE = TILE_DEF
) (
  input logic             I_HCLK,
  input logic             I_HRESET_N,
  rotate_tile_sched_if.master bus
);

  localparam int          SH        = $clog2(TILE);
  localparam logic [15:0] TILE_MASK = 16'(TILE - 1);

  state_t      state;
  logic [15:0] h_q, w_q, tx, ty, tw, th;
  logic [1:0]  rot_q;
  logic        rd_req, wr_req, core_start, busy, done, err;
  logic        cfg_bad, last_col, last_row;
  logic [31:0] rd_ofs, wr_ofs;

  assign tw       = w_q >> SH;
  assign th       = h_q >> SH;
  assign cfg_bad  = (w_q == 16'd0) || (h_q == 16'd0) ||
                    ((w_q & TILE_MASK) != 16'd0) || ((h_q & TILE_MASK) != 16'd0);
  assign last_col = (tx == tw - 16'd1);
  assign last_row = (ty == th - 16'd1);

  rotate_tile_addr #(.TILE(TILE)) u_addr (
    .tx     (tx),
    .ty     (ty),
    .tw     (tw),
    .th     (th),
    .w      (w_q),
    .h      (h_q),
    .rot    (rot_q),
    .rd_ofs (rd_ofs),
    .wr_ofs (wr_ofs)
  );

  // Outputs are registered alongside the state so they line up with it.
  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      state      <= ST_IDLE;
      h_q        <= '0;
      w_q        <= '0;
      rot_q      <= ROT_0;
      tx         <= '0;
      ty         <= '0;
      rd_req     <= 1'b0;
      wr_req     <= 1'b0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= 1'b0;
      done       <= 1'b0;
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.I_START) begin
            h_q   <= bus.I_HEIGHT;
            w_q   <= bus.I_WIDTH;
            rot_q <= norm_rot(bus.I_DEGREES, bus.I_DIRECTION);
            tx    <= '0;
            ty    <= '0;
            busy  <= 1'b1;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cfg_bad) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            rd_req <= 1'b1;
            state  <= ST_RD;
          end
        end
        ST_RD: begin
          if (bus.I_DMA_RD_DONE) begin
            rd_req     <= 1'b0;
            core_start <= 1'b1;
            state      <= ST_CORE;
          end
        end
        ST_CORE: state <= ST_CORE_WAIT;
        ST_CORE_WAIT: begin
          if (bus.I_CORE_DONE) begin
            wr_req <= 1'b1;
            state  <= ST_WR;
          end
        end
        ST_WR: begin
          if (bus.I_DMA_WR_DONE) begin
            wr_req <= 1'b0;
            state  <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last_col && last_row) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            if (last_col) begin
              tx <= '0;
              ty <= ty + 16'd1;
            end else begin
              tx <= tx + 16'd1;
            end
            rd_req <= 1'b1;
            state  <= ST_RD;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.O_DMA_RD_REQ = rd_req;
  assign bus.O_DMA_RD_OFS = rd_ofs;
  assign bus.O_CORE_START = core_start;
  assign bus.O_DMA_WR_REQ = wr_req;
  assign bus.O_DMA_WR_OFS = wr_ofs;
  assign bus.O_BUSY       = busy;
  assign bus.O_DONE       = done;
  assign bus.O_ERR        = err;

endmodule

// File: doc/rotate_tile_sched.md
ROTATE_TILE_SCHED -- requirements
Module: rotate_tile_sched

Interface
REQ-001 SHALL have parameter TILE, default 8, tile edge in pixels (power of two).
REQ-002 SHALL have ports: I_HCLK in 1 clock; I_HRESET_N in 1 async active-low reset.
REQ-003 SHALL have ports: I_START in 1 job start pulse; I_HEIGHT in 16 image rows; I_WIDTH in 16 image columns; I_DEGREES in 2 (0=0, 1=90, 2=180, 3=270); I_DIRECTION in 1 (0=CW, 1=CCW).
REQ-004 SHALL have ports: O_DMA_RD_REQ out 1; O_DMA_RD_OFS out 32 source tile pixel offset; I_DMA_RD_DONE in 1 pulse.
REQ-005 SHALL have ports: O_CORE_START out 1 pulse to core_pixel; I_CORE_DONE in 1 pulse.
REQ-006 SHALL have ports: O_DMA_WR_REQ out 1; O_DMA_WR_OFS out 32 destination tile pixel offset; I_DMA_WR_DONE in 1 pulse.
REQ-007 SHALL have ports: O_BUSY out 1; O_DONE out 1 pulse; O_ERR out 1 pulse.

Function
REQ-008 SHALL implement states IDLE, CHECK, RD, CORE, CORE_WAIT, WR, NEXT, FIN.
REQ-009 SHALL in IDLE latch HEIGHT/WIDTH/DEGREES/DIRECTION when I_START=1 and go to CHECK; I_START outside IDLE ignored.
REQ-010 SHALL in CHECK pulse O_ERR one cycle and return to IDLE, no requests issued, if H or W is 0 or not a multiple of TILE; else go to RD.
REQ-011 SHALL normalise rotation: rot = DIRECTION ? (4-DEGREES) mod 4 : DEGREES (CW quarter turns).
REQ-012 SHALL visit tiles (tx,ty) in raster order, tx fastest, TW=W/TILE, TH=H/TILE, both starting at 0.
REQ-013 SHALL drive O_DMA_RD_OFS = ty*TILE*W + tx*TILE, stable while O_DMA_RD_REQ=1.
REQ-014 SHALL map destination tile: rot0 (tx,ty); rot1 (TH-1-ty, tx); rot2 (TW-1-tx, TH-1-ty); rot3 (ty, TW-1-tx).
REQ-015 SHALL drive O_DMA_WR_OFS = ty'*TILE*W' + tx'*TILE, W'=H for rot 1/3 else W, stable while O_DMA_WR_REQ=1.
REQ-016 SHALL hold O_DMA_RD_REQ high throughout RD, deassert on the cycle after I_DMA_RD_DONE is sampled, then enter CORE.
REQ-017 SHALL pulse O_CORE_START exactly one cycle in CORE, then wait in CORE_WAIT for I_CORE_DONE.
REQ-018 SHALL hold O_DMA_WR_REQ high throughout WR, deassert after I_DMA_WR_DONE, then enter NEXT.
REQ-019 SHALL in NEXT advance tx (wrap to 0 at TW, increment ty); after tile (TW-1,TH-1) go to FIN, else RD.
REQ-020 SHALL in FIN pulse O_DONE one cycle and return to IDLE.
REQ-021 SHALL ignore DONE inputs arriving in states not waiting for them.
REQ-022 SHALL assert O_BUSY in every state except IDLE.
REQ-023 SHALL assert O_DMA_RD_REQ two cycles after I_START is sampled for a valid job.
REQ-024 SHALL keep all offset arithmetic 32-bit unsigned, no saturation.

Reset
REQ-025 SHALL on I_HRESET_N=0 asynchronously enter IDLE, clear tile counters and latched config, and drive all outputs 0.
REQ-026 SHALL abandon an in-progress job on reset without O_DONE or O_ERR.

Structure
REQ-027 SHALL take state encoding, TILE default and rotation codes from shared package rotate_pkg.
REQ-028 SHALL place REQ-013..015 offset arithmetic in sub-module rotate_tile_addr (combinational, from tx, ty, TW, TH, W, H, rot).

Verification
REQ-029 SHALL test W=8,H=8,DEG=1,CW: one tile, RD_OFS=0, WR_OFS=0, single CORE_START, O_DONE once.
REQ-030 SHALL test W=16,H=8,DEG=1,CW: RD_OFS 0,8; WR_OFS 0,64; O_DONE after second WR_DONE.
REQ-031 SHALL test W=16,H=16,DEG=2: tile (0,0) WR_OFS=136; tile (1,1) WR_OFS=0.
REQ-032 SHALL test W=16,H=8,DEG=1,CCW: tile (0,0) WR_OFS=64, tile (1,0) WR_OFS=0.
REQ-033 SHALL test W=12,H=8 START: O_ERR one cycle, no REQ, O_BUSY low after.
REQ-034 SHALL test reset asserted in CORE_WAIT: outputs 0 immediately; new START runs full job normally.
